// File: rtl/nest_score_tally.sv
// nest_score_tally: per-nest delivered-sugar scoreboard fed by the ant array.
// Rising edges of drop_sugar are latched into a pending mask. A round-robin
// arbiter serves one pending ant per clock and credits that ant's home nest
// with a saturating +1. Totals and the leading nest are registered from the
// score registers, so they trail the scores by one cycle.
module nest_score_tally #(
  parameter int ANT_num       = 16,
  parameter int ANT_num_bits  = 4,
  parameter int NEST_num      = 2,
  parameter int NEST_num_bits = 1,
  parameter int SCORE_bits    = 12
) (
  input  logic                                   clk,
  input  logic                                   RESET_SIM,
  input  logic                                   RUN,
  input  logic                                   clear_scores,
  input  logic [ANT_num-1:0]                     drop_sugar,
  input  logic [ANT_num-1:0][NEST_num_bits-1:0]  ant_nest_id,
  output logic [NEST_num-1:0][SCORE_bits-1:0]    score,
  output logic [SCORE_bits+NEST_num_bits-1:0]    total_score,
  output logic [NEST_num_bits-1:0]               leader_id,
  output logic                                   event_valid,
  output logic [NEST_num_bits-1:0]               event_nest,
  output logic [SCORE_bits-1:0]                  lost_count,
  output logic                                   pending_any
);

  localparam int TOTAL_bits = SCORE_bits + NEST_num_bits;
  localparam logic [SCORE_bits-1:0] SCORE_MAX = '1;

  // State registers
  logic [ANT_num-1:0]                  prevDrop_q;
  logic [ANT_num-1:0]                  pending_q,    pending_d;
  logic [ANT_num_bits-1:0]             arbPtr_q,     arbPtr_d;
  logic [NEST_num-1:0][SCORE_bits-1:0] score_q,      score_d;
  logic [TOTAL_bits-1:0]               totalScore_q, totalScore_d;
  logic [NEST_num_bits-1:0]            leaderId_q,   leaderId_d;
  logic                                eventValid_q, eventValid_d;
  logic [NEST_num_bits-1:0]            eventNest_q,  eventNest_d;
  logic [SCORE_bits-1:0]               lostCount_q,  lostCount_d;

  // Combinational helpers
  logic [ANT_num-1:0]        dropEvent;
  logic [ANT_num-1:0]        overrunVec;
  logic [ANT_num_bits:0]     overrunCnt;
  logic [SCORE_bits:0]       lostSum;
  logic [ANT_num-1:0]        grantMask;
  logic                      grantValid;
  logic [ANT_num_bits-1:0]   grantIdx;
  logic [ANT_num_bits-1:0]   candIdx;
  logic [NEST_num_bits-1:0]  grantNest;
  logic                      grantNestOk;
  logic [SCORE_bits-1:0]     bestScore;

  // Round-robin search for the first pending ant starting at the pointer; frozen while RUN is low
  always_comb begin
    grantValid = 1'b0;
    grantIdx   = '0;
    grantMask  = '0;
    candIdx    = '0;
    if (RUN) begin
      for (int k = 0; k < ANT_num; k++) begin
        candIdx = ANT_num_bits'((int'(arbPtr_q) + k) % ANT_num);
        if (!grantValid && pending_q[candIdx]) begin
          grantValid = 1'b1;
          grantIdx   = candIdx;
        end
      end
      if (grantValid) begin
        grantMask[grantIdx] = 1'b1;
      end
    end
  end

  // Edge capture into the pending mask, counting re-triggers of an ant that is still waiting
  always_comb begin
    dropEvent  = drop_sugar & ~prevDrop_q & {ANT_num{RUN}};
    overrunVec = dropEvent & pending_q & ~grantMask;
    pending_d  = (pending_q & ~grantMask) | dropEvent;
    overrunCnt = '0;
    for (int i = 0; i < ANT_num; i++) begin
      overrunCnt = overrunCnt + (ANT_num_bits+1)'(overrunVec[i]);
    end
    lostSum = {1'b0, lostCount_q} + (SCORE_bits+1)'(overrunCnt);
    if (lostSum[SCORE_bits]) begin
      lostCount_d = SCORE_MAX;
    end else begin
      lostCount_d = lostSum[SCORE_bits-1:0];
    end
  end

  // Pointer moves just past the granted ant so every ant gets its turn
  always_comb begin
    arbPtr_d = arbPtr_q;
    if (grantValid) begin
      arbPtr_d = ANT_num_bits'((int'(grantIdx) + 1) % ANT_num);
    end
  end

  // Credit the granted ant's nest as sampled now; ids outside the nest range are silently consumed
  always_comb begin
    grantNest    = ant_nest_id[grantIdx];
    grantNestOk  = ({1'b0, grantNest} < (NEST_num_bits+1)'(NEST_num));
    score_d      = score_q;
    eventValid_d = 1'b0;
    eventNest_d  = eventNest_q;
    if (grantValid && grantNestOk) begin
      eventValid_d = 1'b1;
      eventNest_d  = grantNest;
      for (int n = 0; n < NEST_num; n++) begin
        if ((NEST_num_bits'(n) == grantNest) && (score_q[n] != SCORE_MAX)) begin
          score_d[n] = score_q[n] + SCORE_bits'(1);
        end
      end
    end
  end

  // Exact total and leader from the current scores; strict compare keeps ties on the lowest id
  always_comb begin
    totalScore_d = '0;
    bestScore    = score_q[0];
    leaderId_d   = '0;
    for (int n = 0; n < NEST_num; n++) begin
      totalScore_d = totalScore_d + TOTAL_bits'(score_q[n]);
    end
    for (int n = 1; n < NEST_num; n++) begin
      if (score_q[n] > bestScore) begin
        bestScore  = score_q[n];
        leaderId_d = NEST_num_bits'(n);
      end
    end
  end

  // Register update: reset wipes everything, clear keeps the arbiter pointer, otherwise advance
  always_ff @(posedge clk) begin
    if (RESET_SIM) begin
      prevDrop_q   <= '0;
      pending_q    <= '0;
      arbPtr_q     <= '0;
      score_q      <= '0;
      totalScore_q <= '0;
      leaderId_q   <= '0;
      eventValid_q <= 1'b0;
      eventNest_q  <= '0;
      lostCount_q  <= '0;
    end else if (clear_scores) begin
      prevDrop_q   <= '0;
      pending_q    <= '0;
      score_q      <= '0;
      totalScore_q <= '0;
      leaderId_q   <= '0;
      eventValid_q <= 1'b0;
      eventNest_q  <= '0;
      lostCount_q  <= '0;
    end else begin
      prevDrop_q   <= drop_sugar;
      pending_q    <= pending_d;
      arbPtr_q     <= arbPtr_d;
      score_q      <= score_d;
      totalScore_q <= totalScore_d;
      leaderId_q   <= leaderId_d;
      eventValid_q <= eventValid_d;
      eventNest_q  <= eventNest_d;
      lostCount_q  <= lostCount_d;
    end
  end

  assign score       = score_q;
  assign total_score = totalScore_q;
  assign leader_id   = leaderId_q;
  assign event_valid = eventValid_q;
  assign event_nest  = eventNest_q;
  assign lost_count  = lostCount_q;
  assign pending_any = |pending_q;

endmodule

// File: tb/tb_nest_score_tally.sv
// tb_nest_score_tally: self-checking bench for nest_score_tally.
// Inputs change and outputs are sampled on the falling clock edge. Every
// expected delivery is pushed onto a queue when its drop is driven; a monitor
// pops and compares whenever event_valid is seen.
module tb_nest_score_tally;

  logic              clk;
  logic              RESET_SIM;
  logic              RUN;
  logic              clear_scores;
  logic [15:0]       drop_sugar;
  logic [15:0][0:0]  ant_nest_id;
  logic [1:0][11:0]  score;
  logic [12:0]       total_score;
  logic [0:0]        leader_id;
  logic              event_valid;
  logic [0:0]        event_nest;
  logic [11:0]       lost_count;
  logic              pending_any;

  int checkCount = 0;
  int passCount  = 0;
  int expQ[$];
  int monExp;

  typedef struct {
    int ant;
    int nest;
    int expS0;
    int expS1;
    int expLeader;
  } vec_t;

  vec_t vecs[6];

  nest_score_tally dut (
    .clk          (clk),
    .RESET_SIM    (RESET_SIM),
    .RUN          (RUN),
    .clear_scores (clear_scores),
    .drop_sugar   (drop_sugar),
    .ant_nest_id  (ant_nest_id),
    .score        (score),
    .total_score  (total_score),
    .leader_id    (leader_id),
    .event_valid  (event_valid),
    .event_nest   (event_nest),
    .lost_count   (lost_count),
    .pending_any  (pending_any)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [15:0] pattern);
    drop_sugar = pattern;
    tick(1);
  endtask

  task automatic setDefaultNests();
    for (int i = 0; i < 16; i++) begin
      ant_nest_id[i] = 1'(i % 2);
    end
  endtask

  task automatic doReset();
    RESET_SIM = 1'b1;
    tick(1);
    RESET_SIM = 1'b0;
    expQ.delete();
  endtask

  // Scoreboard monitor: every event must match the oldest expected nest
  always @(negedge clk) begin
    if (event_valid) begin
      if (expQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpected_event actual=nest %0d required=no event", event_nest);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("event_nest_sb", int'(event_nest), monExp);
      end
    end
  end

  initial begin
    vecs[0] = '{ant: 0,  nest: 0, expS0: 1, expS1: 0, expLeader: 0};
    vecs[1] = '{ant: 7,  nest: 1, expS0: 1, expS1: 1, expLeader: 0};
    vecs[2] = '{ant: 15, nest: 1, expS0: 1, expS1: 2, expLeader: 1};
    vecs[3] = '{ant: 8,  nest: 0, expS0: 2, expS1: 2, expLeader: 0};
    vecs[4] = '{ant: 3,  nest: 0, expS0: 3, expS1: 2, expLeader: 0};
    vecs[5] = '{ant: 12, nest: 1, expS0: 3, expS1: 3, expLeader: 0};

    RESET_SIM    = 1'b1;
    RUN          = 1'b1;
    clear_scores = 1'b0;
    drop_sugar   = '0;
    setDefaultNests();
    tick(2);
    checkOutput("rst_score0", int'(score[0]), 0);
    checkOutput("rst_score1", int'(score[1]), 0);
    checkOutput("rst_total", int'(total_score), 0);
    checkOutput("rst_leader", int'(leader_id), 0);
    checkOutput("rst_event_valid", int'(event_valid), 0);
    checkOutput("rst_event_nest", int'(event_nest), 0);
    checkOutput("rst_lost", int'(lost_count), 0);
    checkOutput("rst_pending_any", int'(pending_any), 0);
    RESET_SIM = 1'b0;
    tick(1);

    // Single one-cycle drop on ant 3 (nest 1)
    expQ.push_back(1);
    applyStimulus(16'h0008);
    drop_sugar = '0;
    checkOutput("single_ev_t1", int'(event_valid), 0);
    tick(1);
    checkOutput("single_ev_t2", int'(event_valid), 1);
    checkOutput("single_nest_t2", int'(event_nest), 1);
    checkOutput("single_score1_t2", int'(score[1]), 1);
    checkOutput("single_total_t2", int'(total_score), 0);
    tick(1);
    checkOutput("single_total_t3", int'(total_score), 1);
    checkOutput("single_leader_t3", int'(leader_id), 1);
    checkOutput("single_ev_t3", int'(event_valid), 0);

    // Table of isolated drops after a clear
    clear_scores = 1'b1;
    tick(1);
    clear_scores = 1'b0;
    checkOutput("clear_score1", int'(score[1]), 0);
    checkOutput("clear_total", int'(total_score), 0);
    for (int i = 0; i < 6; i++) begin
      logic [15:0] pat;
      pat = '0;
      pat[vecs[i].ant] = 1'b1;
      ant_nest_id[vecs[i].ant] = 1'(vecs[i].nest);
      expQ.push_back(vecs[i].nest);
      applyStimulus(pat);
      drop_sugar = '0;
      tick(2);
      checkOutput($sformatf("vec%0d_score0", i), int'(score[0]), vecs[i].expS0);
      checkOutput($sformatf("vec%0d_score1", i), int'(score[1]), vecs[i].expS1);
      checkOutput($sformatf("vec%0d_total", i), int'(total_score), vecs[i].expS0 + vecs[i].expS1);
      checkOutput($sformatf("vec%0d_leader", i), int'(leader_id), vecs[i].expLeader);
    end
    setDefaultNests();

    // Simultaneous drops on ants 0,5,9 served in pointer order
    doReset();
    ant_nest_id[9] = 1'b0;
    expQ.push_back(0);
    expQ.push_back(1);
    expQ.push_back(0);
    applyStimulus(16'h0221);
    drop_sugar = '0;
    tick(1);
    checkOutput("simul_s0_a", int'(score[0]), 1);
    checkOutput("simul_s1_a", int'(score[1]), 0);
    tick(1);
    checkOutput("simul_s1_b", int'(score[1]), 1);
    checkOutput("simul_pend_b", int'(pending_any), 1);
    tick(1);
    checkOutput("simul_s0_c", int'(score[0]), 2);
    checkOutput("simul_pend_c", int'(pending_any), 0);
    checkOutput("simul_nest_c", int'(event_nest), 0);
    setDefaultNests();

    // Held level counts once
    expQ.push_back(0);
    drop_sugar = 16'h0004;
    tick(10);
    drop_sugar = '0;
    tick(4);
    checkOutput("held_score0", int'(score[0]), 3);
    checkOutput("held_lost", int'(lost_count), 0);
    checkOutput("held_queue", expQ.size(), 0);

    // RUN low freezes a pending grant
    expQ.push_back(0);
    applyStimulus(16'h0040);
    RUN = 1'b0;
    drop_sugar = '0;
    tick(5);
    checkOutput("freeze_pending", int'(pending_any), 1);
    checkOutput("freeze_score0", int'(score[0]), 3);
    RUN = 1'b1;
    tick(2);
    checkOutput("resume_score0", int'(score[0]), 4);
    checkOutput("resume_pending", int'(pending_any), 0);

    // Level already high when RUN rises is not counted
    RUN = 1'b0;
    drop_sugar = 16'h0040;
    tick(3);
    RUN = 1'b1;
    tick(5);
    drop_sugar = '0;
    tick(1);
    checkOutput("runrise_score0", int'(score[0]), 4);

    // Overrun: all 16 pending, ant 15 re-pulses before it is served
    doReset();
    for (int i = 0; i < 16; i++) begin
      expQ.push_back(i % 2);
    end
    applyStimulus(16'hFFFF);
    applyStimulus(16'h0000);
    applyStimulus(16'h8000);
    drop_sugar = '0;
    tick(20);
    checkOutput("ovr_lost", int'(lost_count), 1);
    checkOutput("ovr_total", int'(total_score), 16);
    checkOutput("ovr_score0", int'(score[0]), 8);
    checkOutput("ovr_score1", int'(score[1]), 8);
    checkOutput("ovr_pending", int'(pending_any), 0);
    checkOutput("ovr_queue", expQ.size(), 0);

    // Reset in the middle of a backlog drain
    doReset();
    for (int i = 0; i < 16; i++) begin
      expQ.push_back(i % 2);
    end
    applyStimulus(16'hFFFF);
    drop_sugar = '0;
    tick(3);
    RESET_SIM = 1'b1;
    tick(1);
    RESET_SIM = 1'b0;
    checkOutput("mid_score0", int'(score[0]), 0);
    checkOutput("mid_score1", int'(score[1]), 0);
    checkOutput("mid_total", int'(total_score), 0);
    checkOutput("mid_leader", int'(leader_id), 0);
    checkOutput("mid_event_valid", int'(event_valid), 0);
    checkOutput("mid_pending", int'(pending_any), 0);
    checkOutput("mid_lost", int'(lost_count), 0);
    expQ.delete();
    tick(20);
    checkOutput("mid_quiet_score0", int'(score[0]), 0);
    expQ.push_back(0);
    applyStimulus(16'h0010);
    drop_sugar = '0;
    tick(3);
    checkOutput("mid_new_score0", int'(score[0]), 1);
    checkOutput("mid_new_queue", expQ.size(), 0);

    // Saturation and tie: fill both nests to the maximum
    doReset();
    for (int k = 0; k < 4095; k++) begin
      expQ.push_back(0);
      expQ.push_back(1);
      applyStimulus(16'h0003);
      applyStimulus(16'h0000);
    end
    tick(4);
    checkOutput("sat_fill_score0", int'(score[0]), 4095);
    checkOutput("sat_fill_score1", int'(score[1]), 4095);
    checkOutput("sat_fill_lost", int'(lost_count), 0);
    expQ.push_back(0);
    applyStimulus(16'h0001);
    drop_sugar = '0;
    tick(3);
    checkOutput("sat_score0", int'(score[0]), 4095);
    checkOutput("sat_total", int'(total_score), 8190);
    checkOutput("sat_leader", int'(leader_id), 0);
    checkOutput("sat_event_nest", int'(event_nest), 0);

    tick(2);
    checkOutput("final_queue", expQ.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
